// File: rtl/rvm_mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
// FSM states and requester (owner) identifiers.
package rvm_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RVM_ST_IDLE = 2'd0,
        RVM_ST_REQ  = 2'd1,
        RVM_ST_WAIT = 2'd2
    } rvm_state_e;

    localparam logic RVM_OWN_IF = 1'b0;
    localparam logic RVM_OWN_DM = 1'b1;

    function automatic logic rvm_other_owner(input logic own);
        return ~own;
    endfunction

endpackage

// File: rtl/rvm_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker; purely combinational.
// On a tie the requester that was not served last wins.
module rvm_rr_pick2
    import rvm_mem_arbiter_pkg::*;
(
    input  logic i_req_if,
    input  logic i_req_dm,
    input  logic i_last,
    output logic o_owner,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req_if | i_req_dm;
        o_owner = RVM_OWN_IF;
        if (i_req_if && i_req_dm) begin
            o_owner = rvm_other_owner(i_last);
        end else if (i_req_dm) begin
            o_owner = RVM_OWN_DM;
        end
    end

endmodule

// File: rtl/rvm_mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port.
// Single outstanding transaction; WAIT is bounded by a timeout.
module rvm_mem_arbiter
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_error,

    input  logic                  dm_req,
    input  logic                  dm_wen,
    input  logic [DATA_W/8-1:0]   dm_strb,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_error,

    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [DATA_W/8-1:0]   mem_strb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_error
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    rvm_state_e          r_state;
    rvm_state_e          w_state_nxt;
    logic                r_owner;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [STRB_W-1:0]   r_strb;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_pick_owner;
    logic                w_pick_valid;
    logic                w_mem_req;
    logic                w_gnt;
    logic                w_rsp;
    logic                w_rsp_err;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_timeout;
    logic                w_own_if;
    logic                w_own_dm;

    rvm_rr_pick2 u_pick (
        .i_req_if (if_req),
        .i_req_dm (dm_req),
        .i_last   (r_last),
        .o_owner  (w_pick_owner),
        .o_valid  (w_pick_valid)
    );

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_gnt       = 1'b0;
        w_rsp       = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = '0;
        unique case (r_state)
            RVM_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = RVM_ST_REQ;
                end
            end
            RVM_ST_REQ: begin
                w_mem_req = 1'b1;
                if (mem_gnt) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = RVM_ST_WAIT;
                end
            end
            RVM_ST_WAIT: begin
                if (mem_rvalid) begin
                    w_rsp       = 1'b1;
                    w_rsp_data  = mem_rdata;
                    w_rsp_err   = mem_error;
                    w_state_nxt = RVM_ST_IDLE;
                end else if (w_timeout) begin
                    w_rsp       = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_state_nxt = RVM_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = RVM_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RVM_ST_IDLE;
            r_owner <= RVM_OWN_IF;
            r_last  <= RVM_OWN_IF;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RVM_ST_IDLE && w_pick_valid) begin
                r_owner <= w_pick_owner;
                if (w_pick_owner == RVM_OWN_DM) begin
                    r_addr  <= dm_addr;
                    r_wen   <= dm_wen;
                    r_strb  <= dm_strb;
                    r_wdata <= dm_wdata;
                end else begin
                    r_addr  <= if_addr;
                    r_wen   <= 1'b0;
                    r_strb  <= {STRB_W{1'b1}};
                    r_wdata <= '0;
                end
            end
            // Counter only advances while waiting; it stops at TIMEOUT.
            if (r_state == RVM_ST_REQ && mem_gnt) begin
                r_last <= r_owner;
                r_cnt  <= '0;
            end else if (r_state == RVM_ST_WAIT && !mem_rvalid && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_own_if = (r_owner == RVM_OWN_IF) && !reset;
    assign w_own_dm = (r_owner == RVM_OWN_DM) && !reset;

    assign mem_req   = w_mem_req && !reset;
    assign mem_wen   = r_wen;
    assign mem_strb  = r_strb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_gnt    = w_gnt && w_own_if;
    assign if_rvalid = w_rsp && w_own_if;
    assign if_error  = w_rsp && w_own_if && w_rsp_err;
    assign if_rdata  = (w_rsp && w_own_if) ? w_rsp_data : '0;

    assign dm_gnt    = w_gnt && w_own_dm;
    assign dm_rvalid = w_rsp && w_own_dm;
    assign dm_error  = w_rsp && w_own_dm && w_rsp_err;
    assign dm_rdata  = (w_rsp && w_own_dm) ? w_rsp_data : '0;

endmodule
